// File: rtl/tdc_fifo_arbiter_pkg.sv
// tdc_fifo_arbiter_pkg: shared FSM encoding and index-width helper for the TDC FIFO merger
package tdc_fifo_arbiter_pkg;
  typedef enum logic {SELECT, GRANT} state_t;
  function automatic int idx_w(int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/tdc_fifo_arbiter_if.sv
// tdc_fifo_arbiter_if: channel FIFO side and downstream FIFO side of the merger
interface tdc_fifo_arbiter_if #(
  parameter int N_CH = 4,
  parameter int DATA_WIDTH = 32
);
  logic [N_CH-1:0] CH_EN;
  logic [N_CH-1:0] CH_FIFO_EMPTY;
  logic [N_CH-1:0] CH_FIFO_READ;
  logic [N_CH*DATA_WIDTH-1:0] CH_FIFO_DATA;
  logic FIFO_READ;
  logic FIFO_EMPTY;
  logic [DATA_WIDTH-1:0] FIFO_DATA;
  logic [3:0] FIFO_CH;
  logic READ_ERR;
  modport master (
    input CH_EN, CH_FIFO_EMPTY, CH_FIFO_DATA, FIFO_READ,
    output CH_FIFO_READ, FIFO_EMPTY, FIFO_DATA, FIFO_CH, READ_ERR
  );
  modport slave (
    output CH_EN, CH_FIFO_EMPTY, CH_FIFO_DATA, FIFO_READ,
    input CH_FIFO_READ, FIFO_EMPTY, FIFO_DATA, FIFO_CH, READ_ERR
  );
endinterface

// File: rtl/tdc_fifo_arbiter_rr_select.sv
// tdc_fifo_arbiter_rr_select: combinational round-robin pick, searching last+1 .. last (mod N)
module tdc_fifo_arbiter_rr_select #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] eligible,
  input  logic [W-1:0] last,
  output logic [W-1:0] next,
  output logic         found
);
  logic [2*N-1:0] rot;
  // rot[j] is the eligibility of channel (last+1+j) mod N; lowest j wins
  always_comb begin
    rot = {eligible, eligible} >> (int'(last) + 1);
    next = last;
    for (int j = N - 1; j >= 0; j--)
      if (rot[j]) next = W'((int'(last) + 1 + j) % N);
  end
  assign found = |eligible;
endmodule

// File: rtl/tdc_fifo_arbiter.sv
// tdc_fifo_arbiter: round-robin, burst-limited merger of N_CH FWFT TDC FIFOs into one output register
module tdc_fifo_arbiter
  import tdc_fifo_arbiter_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int BURST = 8
) (
  input logic BUS_CLK,
  input logic BUS_RST,
  tdc_fifo_arbiter_if.master bus
);
  localparam int GW = idx_w(N_CH);
  state_t state, state_n;
  logic [GW-1:0] g, g_n, sel;
  logic [7:0] cnt, cnt_n;
  logic [N_CH-1:0] eligible;
  logic found, load, pop;
  logic out_valid, read_err;
  logic [DATA_WIDTH-1:0] out_data;
  logic [3:0] out_ch;
  assign eligible = bus.CH_EN & ~bus.CH_FIFO_EMPTY;
  assign load = !out_valid || bus.FIFO_READ;
  tdc_fifo_arbiter_rr_select #(.N(N_CH), .W(GW)) u_rr_select (
    .eligible(eligible),
    .last(g),
    .next(sel),
    .found(found)
  );
  always_comb begin
    state_n = state;
    g_n = g;
    cnt_n = cnt;
    pop = 1'b0;
    if (state == SELECT) begin
      if (found) begin
        state_n = GRANT;
        g_n = sel;
        cnt_n = '0;
      end
    end else if (!eligible[g] || cnt == 8'(BURST)) begin
      state_n = SELECT;
    end else if (load) begin
      pop = 1'b1;
      cnt_n = cnt + 8'd1;
    end
  end
  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      state <= SELECT;
      g <= GW'(N_CH - 1);
      cnt <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_ch <= '0;
      read_err <= 1'b0;
    end else begin
      state <= state_n;
      g <= g_n;
      cnt <= cnt_n;
      if (bus.FIFO_READ && !out_valid) read_err <= 1'b1;
      if (load) out_valid <= pop;
      if (pop) begin
        out_data <= bus.CH_FIFO_DATA[g*DATA_WIDTH +: DATA_WIDTH];
        out_ch <= 4'(g);
      end
    end
  end
  assign bus.CH_FIFO_READ = pop ? N_CH'(1) << g : '0;
  assign bus.FIFO_EMPTY = !out_valid;
  assign bus.FIFO_DATA = out_data;
  assign bus.FIFO_CH = out_ch;
  assign bus.READ_ERR = read_err;
endmodule
